// File: rtl/cla_seq_adder.sv
// Sequential multi-precision adder: one 4-bit CLA slice reused per nibble, LSB nibble first.
// Latency: the start is sampled on an edge; done and sum/cout are valid WIDTH/4+1 edges later.
// Backpressure: none; start is ignored while busy, and there is no queuing of requests.
//
// Ports: clk, rst (async, active-high); start/a/b/cin request inputs captured on an accepted start;
//        busy (nibble steps running), done (one-cycle pulse), sum/cout (registered result).
// Optional: define CLA_SEQ_SUB_EN to add input 'sub' (a - b: B inverted, carry-in forced to 1).
module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             load, last;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;

    // Subtraction is folded into capture so the nibble loop only ever adds.
`ifdef CLA_SEQ_SUB_EN
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub ? 1'b1 : cin;
`else
    assign b_in   = b;
    assign cin_in = cin;
`endif

    // Current nibble of each operand, selected by shifting rather than a variable part-select.
    logic [3:0] na, nb, g, p, ns;
    logic [3:0] c;
    logic       nco;
    logic [7:0] shamt;

    assign shamt = 8'({cnt_q, 2'b00});
    assign na    = 4'(a_q >> shamt);
    assign nb    = 4'(b_q >> shamt);
    assign last  = (cnt_q == CW'(NIB - 1));

    // 4-bit carry-lookahead slice.
    always_comb begin
        g    = na & nb;
        p    = na ^ nb;
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & carry_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        nco  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & carry_q);
        ns   = p ^ c;
    end

    // Result with the current nibble slot replaced by the slice sum.
    assign res_nxt = (res_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(ns) << shamt);

    // Next-state logic; load marks an accepted start (IDLE, or DONE for back-to-back).
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State plus busy/done flops, so the status outputs come straight from registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == RUN);
            done    <= (state_d == DONE);
        end
    end

    // Datapath. sum/cout load only on the final nibble so partial results never show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (load) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= cin_in;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            res_q   <= res_nxt;
            carry_q <= nco;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                sum  <= res_nxt;
                cout <= nco;
            end
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder: directed vectors push expected results, a monitor checks on done.
// Expected done edge = edge where start was driven + NIB + 1.
// Stray or missing done pulses are reported by the monitor and the end-of-run queue check.
module tb_cla_seq_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    logic             sub = 1'b0;
`endif
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        int               cy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: pops one expected entry per done pulse.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("done_cycle", 32'(cyc), 32'(e.cy));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start cycle; pushes the hand-computed result unless push=0.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic icin, input logic isub, input bit push,
                         input logic [WIDTH-1:0] es, input logic ec);
        exp_t e;
        start = 1'b1;
        a     = ia;
        b     = ib;
        cin   = icin;
`ifdef CLA_SEQ_SUB_EN
        sub   = isub;
`else
        if (isub) $display("note: sub requested without CLA_SEQ_SUB_EN");
`endif
        if (push) begin
            e.s  = es;
            e.c  = ec;
            e.cy = cyc + NIB + 1;
            exp_q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (3) tick();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running, want finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int busy_cnt;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // Basic add, busy for exactly NIB cycles
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
        busy_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
        end
        chk("busy_cycles", 32'(busy_cnt), 32'd4);
        #1;
        wait_idle("basic");

        // Start during RUN is ignored; sum holds previous result until done
        issue(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0);
        tick();
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h1111;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("busy_midrun", 32'(busy), 32'd1);
        chk("sum_hold", 32'(sum), 32'h5555);
        #1;
        wait_idle("ignored");
        repeat (8) tick();

        // Full-width carry chains
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        wait_idle("carry1");
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        wait_idle("carry2");

        // Asynchronous abort in RUN cycle 2
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        tick();
        rst = 1'b0;
        repeat (8) tick();

        // Operation after abort
        issue(16'h0FF0, 16'h0010, 1'b1, 1'b0, 1'b1, 16'h1001, 1'b0);
        wait_idle("post_abort");

        // Back-to-back with start held high
        begin
            exp_t e1, e2;
            start = 1'b1;
            a     = 16'h000F;
            b     = 16'h0001;
            cin   = 1'b0;
            e1.s = 16'h0010; e1.c = 1'b0; e1.cy = cyc + NIB + 1;
            e2.s = 16'h0000; e2.c = 1'b1; e2.cy = cyc + 2 * (NIB + 1);
            exp_q.push_back(e1);
            exp_q.push_back(e2);
            tick();
            a = 16'h8000;
            b = 16'h8000;
            repeat (NIB + 1) tick();
            start = 1'b0;
            wait_idle("b2b");
        end

`ifdef CLA_SEQ_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        wait_idle("sub1");
        issue(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0002, 1'b1);
        wait_idle("sub2");
        sub = 1'b0;
`endif

        repeat (5) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
